// File: rtl/cpu_pkg.sv
// Shared control-unit opcode encoding for the RISC core, plus memory-class decode helpers.
// Arbiter state encoding lives here so the bench and RTL agree on FETCH/DATA.
package cpu_pkg;

    typedef enum logic [5:0] {
        CU_LUI   = 6'd0,
        CU_AUIPC,
        CU_JAL,
        CU_JALR,
        CU_BEQ,
        CU_BNE,
        CU_BLT,
        CU_BGE,
        CU_BLTU,
        CU_BGEU,
        CU_LB    = 6'd10,
        CU_LH,
        CU_LW,
        CU_LBU,
        CU_LHU,
        CU_SB,
        CU_SH,
        CU_SW    = 6'd17,
        CU_ADDI,
        CU_SLTI,
        CU_SLTIU,
        CU_XORI,
        CU_ORI,
        CU_ANDI,
        CU_SLLI,
        CU_SRLI,
        CU_SRAI,
        CU_ADD,
        CU_SUB,
        CU_SLL,
        CU_SLT,
        CU_SLTU,
        CU_XOR,
        CU_SRL,
        CU_SRA,
        CU_OR,
        CU_AND,
        CU_ERROR
    } cuOPType;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DATA  = 1'b1
    } req_state_t;

    function automatic logic is_load(input cuOPType op);
        return (op == CU_LB) || (op == CU_LH) || (op == CU_LW) ||
               (op == CU_LBU) || (op == CU_LHU);
    endfunction

    function automatic logic is_store(input cuOPType op);
        return (op == CU_SB) || (op == CU_SH) || (op == CU_SW);
    endfunction

endpackage

// File: rtl/request.sv
// Single-port RAM arbiter: one instruction fetch, then at most one load/store, per instruction.
// Each access completes on the first cycle busy_o is low; busy_o high stalls indefinitely.
module request
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        busy_o,
    input  logic [31:0] imemaddr,
    input  logic [31:0] dmmaddr,
    input  logic [31:0] dmmstore,
    input  logic [31:0] ramload,
    input  cuOPType     cuOP,
    output logic        Ren,
    output logic        Wen,
    output logic [31:0] imemload,
    output logic [31:0] dmmload,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore
);

    req_state_t state;
    logic       op_is_store;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state       <= ST_FETCH;
            op_is_store <= 1'b0;
            imemload    <= '0;
            dmmload     <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!busy_o) begin
                        imemload <= ramload;
                        // Memory class is captured here; cuOP may move on while DATA runs.
                        if (is_load(cuOP)) begin
                            state       <= ST_DATA;
                            op_is_store <= 1'b0;
                        end else if (is_store(cuOP)) begin
                            state       <= ST_DATA;
                            op_is_store <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (!busy_o) begin
                        if (!op_is_store) begin
                            dmmload <= ramload;
                        end
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Outputs are forced idle for the whole reset assertion, not just after the next edge.
    always_comb begin
        Ren      = 1'b0;
        Wen      = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (!nRST) begin
            if (state == ST_FETCH) begin
                ramaddr = imemaddr;
                Ren     = 1'b1;
            end else begin
                ramaddr = dmmaddr;
                if (op_is_store) begin
                    Wen      = 1'b1;
                    ramstore = dmmstore;
                end else begin
                    Ren = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_request.sv
// Directed bench for the fetch/data RAM arbiter with hand-computed expectations.
module tb_request;
    import cpu_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        busy_o;
    logic [31:0] imemaddr;
    logic [31:0] dmmaddr;
    logic [31:0] dmmstore;
    logic [31:0] ramload;
    cuOPType     cuOP;
    logic        Ren;
    logic        Wen;
    logic [31:0] imemload;
    logic [31:0] dmmload;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;

    int n_cmp;
    int n_err;

    request dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .busy_o   (busy_o),
        .imemaddr (imemaddr),
        .dmmaddr  (dmmaddr),
        .dmmstore (dmmstore),
        .ramload  (ramload),
        .cuOP     (cuOP),
        .Ren      (Ren),
        .Wen      (Wen),
        .imemload (imemload),
        .dmmload  (dmmload),
        .ramaddr  (ramaddr),
        .ramstore (ramstore)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        nRST     = 1'b1;
        busy_o   = 1'b0;
        imemaddr = '0;
        dmmaddr  = '0;
        dmmstore = '0;
        ramload  = 32'hFFFF_FFFF;
        cuOP     = CU_LB;

        // Reset held two cycles
        tick();
        tick();
        chk("rst_imemload", imemload, 32'h0);
        chk("rst_dmmload",  dmmload,  32'h0);
        chk("rst_ren",      {31'b0, Ren}, 32'h0);
        chk("rst_wen",      {31'b0, Wen}, 32'h0);
        chk("rst_ramaddr",  ramaddr,  32'h0);

        // Stalled fetch
        nRST     = 1'b0;
        busy_o   = 1'b1;
        imemaddr = 32'hABCD_ABCD;
        ramload  = 32'h1234_1234;
        cuOP     = CU_LW;
        tick();
        tick();
        tick();
        chk("stall_ramaddr",  ramaddr,  32'hABCD_ABCD);
        chk("stall_ren",      {31'b0, Ren}, 32'h1);
        chk("stall_wen",      {31'b0, Wen}, 32'h0);
        chk("stall_imemload", imemload, 32'h0);

        // Load: fetch completes, then data read
        dmmaddr = 32'h5678_5678;
        ramload = 32'h1111_1111;
        busy_o  = 1'b0;
        tick();
        chk("ld_imemload", imemload, 32'h1111_1111);
        chk("ld_ramaddr",  ramaddr,  32'h5678_5678);
        chk("ld_ren",      {31'b0, Ren}, 32'h1);
        chk("ld_wen",      {31'b0, Wen}, 32'h0);
        busy_o = 1'b1;
        cuOP   = CU_SW;
        tick();
        chk("ld_hold_wen",     {31'b0, Wen}, 32'h0);
        chk("ld_hold_ramaddr", ramaddr, 32'h5678_5678);
        chk("ld_hold_dmmload", dmmload, 32'h0);
        busy_o  = 1'b0;
        ramload = 32'h4321_4321;
        tick();
        chk("ld_dmmload",    dmmload,  32'h4321_4321);
        chk("ld_imem_keep",  imemload, 32'h1111_1111);
        chk("ld_back_fetch", ramaddr,  32'hABCD_ABCD);

        // Store
        cuOP     = CU_SW;
        imemaddr = 32'h0000_1000;
        dmmaddr  = 32'hABCD_ABCD;
        dmmstore = 32'h3333_3333;
        ramload  = 32'hAAAA_0001;
        tick();
        chk("st_imemload", imemload, 32'hAAAA_0001);
        chk("st_wen",      {31'b0, Wen}, 32'h1);
        chk("st_ren",      {31'b0, Ren}, 32'h0);
        chk("st_ramaddr",  ramaddr,  32'hABCD_ABCD);
        chk("st_ramstore", ramstore, 32'h3333_3333);
        cuOP    = CU_ADD;
        ramload = 32'hDEAD_BEEF;
        tick();
        chk("st_dmmload_keep", dmmload, 32'h4321_4321);
        chk("st_back_ren",     {31'b0, Ren}, 32'h1);
        chk("st_back_ramstore", ramstore, 32'h0);
        chk("st_back_ramaddr", ramaddr,  32'h0000_1000);

        // Non-memory ops stay in fetch
        ramload = 32'h2323_2323;
        tick();
        chk("nm_imemload", imemload, 32'h2323_2323);
        chk("nm_ren",      {31'b0, Ren}, 32'h1);
        chk("nm_ramaddr",  ramaddr,  32'h0000_1000);
        cuOP    = CU_ERROR;
        ramload = 32'h2424_2424;
        tick();
        chk("err_imemload", imemload, 32'h2424_2424);
        chk("err_ramaddr",  ramaddr,  32'h0000_1000);

        // Async reset mid-data access
        cuOP    = CU_LW;
        dmmaddr = 32'h5678_5678;
        ramload = 32'h5555_5555;
        tick();
        chk("ar_pre_ramaddr", ramaddr, 32'h5678_5678);
        busy_o = 1'b1;
        tick();
        #1;
        nRST = 1'b1;
        #1;
        chk("ar_ren",      {31'b0, Ren}, 32'h0);
        chk("ar_ramaddr",  ramaddr,  32'h0);
        chk("ar_imemload", imemload, 32'h0);
        chk("ar_dmmload",  dmmload,  32'h0);
        tick();
        nRST = 1'b0;
        #1;
        chk("ar_rel_ramaddr", ramaddr, 32'h0000_1000);
        chk("ar_rel_ren",     {31'b0, Ren}, 32'h1);
        chk("ar_rel_wen",     {31'b0, Wen}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
